// File: rtl/regfile_pkg.sv
// Shared defaults and packed-port slicing helpers for the multiport register file.
package regfile_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 5;
  localparam int unsigned DefNumRead   = 4;
  localparam int unsigned DefNumWrite  = 4;
  localparam int unsigned DefZeroReg   = 1;

  // Low bit of slice idx inside a packed per-port bus.
  function automatic int unsigned sliceLo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit array: reserves set a bit, committed writes clear it, reserve wins a same-cycle tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NUM_READ   = DefNumRead,
  parameter int unsigned NUM_WRITE  = DefNumWrite,
  parameter int unsigned ZERO_REG   = DefZeroReg
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic [NUM_WRITE-1:0]            wrValid,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wrAddr,
  input  logic [NUM_WRITE-1:0]            rsvEn,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] rsvAddr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rdAddr,
  output logic [NUM_READ-1:0]             rdPending
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [NumRegs-1:0]  pendQ, pendD;
  logic [NUM_READ-1:0] rdPendingD;

  always_comb begin
    pendD = pendQ;
    for (int unsigned w = 0; w < NUM_WRITE; w++) begin
      if (wrValid[w]) begin
        pendD[wrAddr[sliceLo(w, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b0;
      end
    end
    // Applied after the clears so a same-cycle reserve leaves the bit set.
    for (int unsigned w = 0; w < NUM_WRITE; w++) begin
      if (rsvEn[w] &&
          !(ZERO_REG != 0 && rsvAddr[sliceLo(w, ADDR_WIDTH) +: ADDR_WIDTH] == '0)) begin
        pendD[rsvAddr[sliceLo(w, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
      end
    end
  end

  always_comb begin
    rdPendingD = '0;
    for (int unsigned r = 0; r < NUM_READ; r++) begin
      if (ZERO_REG != 0 && rdAddr[sliceLo(r, ADDR_WIDTH) +: ADDR_WIDTH] == '0) begin
        rdPendingD[r] = 1'b0;
      end else begin
        rdPendingD[r] = pendD[rdAddr[sliceLo(r, ADDR_WIDTH) +: ADDR_WIDTH]];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pendQ     <= '0;
      rdPending <= '0;
    end else begin
      pendQ     <= pendD;
      rdPending <= rdPendingD;
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file with write-first registered reads, collision flag and
// a per-register pending scoreboard.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NUM_READ   = DefNumRead,
  parameter int unsigned NUM_WRITE  = DefNumWrite,
  parameter int unsigned ZERO_REG   = DefZeroReg
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rdAddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rdData,
  output logic [NUM_READ-1:0]             rdPending,
  input  logic [NUM_WRITE-1:0]            wrEn,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wrAddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wrData,
  input  logic [NUM_WRITE-1:0]            rsvEn,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] rsvAddr,
  output logic                            writeConflict
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          memQ [NumRegs];
  logic [DATA_WIDTH-1:0]          memD [NumRegs];
  logic [NUM_WRITE-1:0]           wrValid;
  logic                           conflictD;
  logic [NUM_READ*DATA_WIDTH-1:0] rdDataD;

  // A write to the hardwired zero register is dropped before it reaches any logic.
  always_comb begin
    wrValid = '0;
    for (int unsigned w = 0; w < NUM_WRITE; w++) begin
      wrValid[w] = wrEn[w] &&
                   !(ZERO_REG != 0 && wrAddr[sliceLo(w, ADDR_WIDTH) +: ADDR_WIDTH] == '0);
    end
  end

  // Ascending port order makes the highest-index port win a collision.
  always_comb begin
    memD = memQ;
    for (int unsigned w = 0; w < NUM_WRITE; w++) begin
      if (wrValid[w]) begin
        memD[wrAddr[sliceLo(w, ADDR_WIDTH) +: ADDR_WIDTH]] =
          wrData[sliceLo(w, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    conflictD = 1'b0;
    for (int unsigned i = 0; i < NUM_WRITE; i++) begin
      for (int unsigned j = i + 1; j < NUM_WRITE; j++) begin
        if (wrValid[i] && wrValid[j] &&
            wrAddr[sliceLo(i, ADDR_WIDTH) +: ADDR_WIDTH] ==
            wrAddr[sliceLo(j, ADDR_WIDTH) +: ADDR_WIDTH]) begin
          conflictD = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdDataD = '0;
    for (int unsigned r = 0; r < NUM_READ; r++) begin
      if (ZERO_REG != 0 && rdAddr[sliceLo(r, ADDR_WIDTH) +: ADDR_WIDTH] == '0) begin
        rdDataD[sliceLo(r, DATA_WIDTH) +: DATA_WIDTH] = '0;
      end else begin
        rdDataD[sliceLo(r, DATA_WIDTH) +: DATA_WIDTH] =
          memD[rdAddr[sliceLo(r, ADDR_WIDTH) +: ADDR_WIDTH]];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        memQ[i] <= '0;
      end
      rdData        <= '0;
      writeConflict <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        memQ[i] <= memD[i];
      end
      rdData        <= rdDataD;
      writeConflict <= conflictD;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .resetN    (resetN),
    .wrValid   (wrValid),
    .wrAddr    (wrAddr),
    .rsvEn     (rsvEn),
    .rsvAddr   (rsvAddr),
    .rdAddr    (rdAddr),
    .rdPending (rdPending)
  );

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: default instance checked against a reference model through
// an expected-result queue, plus a wide 64/6/6/2 instance.
module tb_multiport_regfile;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic [19:0]  rdAddr;
  logic [127:0] rdData;
  logic [3:0]   rdPending;
  logic [3:0]   wrEn;
  logic [19:0]  wrAddr;
  logic [127:0] wrData;
  logic [3:0]   rsvEn;
  logic [19:0]  rsvAddr;
  logic         writeConflict;

  multiport_regfile u_dut (
    .clk           (clk),
    .resetN        (resetN),
    .rdAddr        (rdAddr),
    .rdData        (rdData),
    .rdPending     (rdPending),
    .wrEn          (wrEn),
    .wrAddr        (wrAddr),
    .wrData        (wrData),
    .rsvEn         (rsvEn),
    .rsvAddr       (rsvAddr),
    .writeConflict (writeConflict)
  );

  // Wide instance.
  logic [35:0]  bRdAddr;
  logic [383:0] bRdData;
  logic [5:0]   bRdPending;
  logic [1:0]   bWrEn;
  logic [11:0]  bWrAddr;
  logic [127:0] bWrData;
  logic [1:0]   bRsvEn;
  logic [11:0]  bRsvAddr;
  logic         bWriteConflict;

  multiport_regfile #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (6),
    .NUM_READ   (6),
    .NUM_WRITE  (2)
  ) u_dut_wide (
    .clk           (clk),
    .resetN        (resetN),
    .rdAddr        (bRdAddr),
    .rdData        (bRdData),
    .rdPending     (bRdPending),
    .wrEn          (bWrEn),
    .wrAddr        (bWrAddr),
    .wrData        (bWrData),
    .rsvEn         (bRsvEn),
    .rsvAddr       (bRsvAddr),
    .writeConflict (bWriteConflict)
  );

  typedef struct packed {
    logic [3:0][31:0] data;
    logic [3:0]       pend;
    logic             conflict;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Per-port stimulus fields, packed onto the DUT buses by drive_cycle.
  logic [4:0]  ra [4];
  logic [4:0]  wa [4];
  logic [4:0]  sa [4];
  logic [31:0] wd [4];
  logic [3:0]  we;
  logic [3:0]  se;

  // Reference state.
  logic [31:0] mMem  [32];
  logic        mPend [32];

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      ra[i] = '0; wa[i] = '0; sa[i] = '0; wd[i] = '0;
    end
    we = '0;
    se = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      mMem[i]  = '0;
      mPend[i] = 1'b0;
    end
    expQ.delete();
  endtask

  // Applies one cycle of stimulus, advances the model, queues the expected outputs.
  task automatic drive_cycle();
    exp_t e;
    logic conf;
    for (int i = 0; i < 4; i++) begin
      rdAddr[i*5 +: 5]   = ra[i];
      wrAddr[i*5 +: 5]   = wa[i];
      rsvAddr[i*5 +: 5]  = sa[i];
      wrData[i*32 +: 32] = wd[i];
    end
    wrEn  = we;
    rsvEn = se;
    conf  = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (we[i] && we[j] && wa[i] == wa[j] && wa[i] != 5'd0) conf = 1'b1;
    for (int i = 0; i < 4; i++)
      if (we[i] && wa[i] != 5'd0) mMem[wa[i]] = wd[i];
    for (int i = 0; i < 4; i++)
      if (we[i] && wa[i] != 5'd0) mPend[wa[i]] = 1'b0;
    for (int i = 0; i < 4; i++)
      if (se[i] && sa[i] != 5'd0) mPend[sa[i]] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      e.data[r] = (ra[r] == 5'd0) ? 32'd0 : mMem[ra[r]];
      e.pend[r] = (ra[r] == 5'd0) ? 1'b0 : mPend[ra[r]];
    end
    e.conflict = conf;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    checks++;
    if (rdData !== '0 || rdPending !== '0 || writeConflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial got data=%h pend=%b conf=%b want all zero",
               rdData, rdPending, writeConflict);
    end
    resetN = 1'b1;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      we[i] = 1'b1; wa[i] = 5'(i + 1); wd[i] = 32'hA0 + i;
    end
    se[0] = 1'b1; sa[0] = 5'd5;
    drive_cycle();
    void'(expQ.pop_front());
    clear_inputs();
    ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3; ra[3] = 5'd5;
    drive_cycle();
    e = expQ.pop_front();
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (rdData[r*32 +: 32] !== e.data[r] || rdPending[r] !== e.pend[r]) begin
        errors++;
        $display("FAIL prereset_read%0d got %h/%b want %h/%b", r, rdData[r*32 +: 32],
                 rdPending[r], e.data[r], e.pend[r]);
      end
    end
    // Collision in flight when reset lands mid-cycle.
    clear_inputs();
    we = 4'b0011; wa[0] = 5'd3; wa[1] = 5'd3; wd[0] = 32'h1; wd[1] = 32'h2;
    se[1] = 1'b1; sa[1] = 5'd6;
    for (int i = 0; i < 4; i++) begin
      wrAddr[i*5 +: 5] = wa[i]; wrData[i*32 +: 32] = wd[i]; rsvAddr[i*5 +: 5] = sa[i];
    end
    wrEn = we; rsvEn = se;
    #3;
    resetN = 1'b0;
    #1;
    checks++;
    if (rdData !== '0 || rdPending !== '0 || writeConflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got data=%h pend=%b conf=%b want all zero",
               rdData, rdPending, writeConflict);
    end
    @(posedge clk);
    #1;
    checks++;
    if (writeConflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_collision got conf=%b want 0", writeConflict);
    end
    clear_inputs();
    wrEn = '0; rsvEn = '0;
    resetN = 1'b1;
    clear_model();
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 4; r++) ra[r] = 5'(k * 4 + r);
      drive_cycle();
      e = expQ.pop_front();
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (rdData[r*32 +: 32] !== 32'd0 || rdPending[r] !== 1'b0 ||
            e.data[r] !== 32'd0) begin
          errors++;
          $display("FAIL reset_readall reg%0d got %h/%b want 0/0", k * 4 + r,
                   rdData[r*32 +: 32], rdPending[r]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    clear_inputs();
    we[2] = 1'b1; wa[2] = 5'd7; wd[2] = 32'hDEADBEEF;
    ra[0] = 5'd7;
    drive_cycle();
    e = expQ.pop_front();
    checks++;
    if (rdData[31:0] !== 32'hDEADBEEF || rdData[31:0] !== e.data[0]) begin
      errors++;
      $display("FAIL bypass got %h want %h", rdData[31:0], 32'hDEADBEEF);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    clear_inputs();
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h11;
    we[3] = 1'b1; wa[3] = 5'd9; wd[3] = 32'h33;
    ra[1] = 5'd9;
    drive_cycle();
    e = expQ.pop_front();
    checks++;
    if (writeConflict !== 1'b1 || e.conflict !== 1'b1) begin
      errors++;
      $display("FAIL collision_flag got %b want 1", writeConflict);
    end
    checks++;
    if (rdData[63:32] !== 32'h33) begin
      errors++;
      $display("FAIL collision_bypass got %h want %h", rdData[63:32], 32'h33);
    end
    clear_inputs();
    ra[0] = 5'd9;
    drive_cycle();
    e = expQ.pop_front();
    checks++;
    if (writeConflict !== 1'b0 || rdData[31:0] !== 32'h33 || rdData[31:0] !== e.data[0]) begin
      errors++;
      $display("FAIL collision_after got conf=%b data=%h want 0/%h",
               writeConflict, rdData[31:0], 32'h33);
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [3:0] wantPend [4];
    clear_inputs();
    se[0] = 1'b1; sa[0] = 5'd4;
    drive_cycle();
    void'(expQ.pop_front());
    wantPend[0] = 1'b1;
    wantPend[1] = 1'b0;
    wantPend[2] = 1'b1;
    wantPend[3] = 1'b1;
    for (int step = 0; step < 4; step++) begin
      clear_inputs();
      if (step == 1) begin
        we[1] = 1'b1; wa[1] = 5'd4; wd[1] = 32'h44;
      end else if (step == 2) begin
        we[3] = 1'b1; wa[3] = 5'd4; wd[3] = 32'h55;
        se[2] = 1'b1; sa[2] = 5'd4;
      end else if (step == 3) begin
        se[1] = 1'b1; sa[1] = 5'd4;
      end
      if (step != 0) begin
        drive_cycle();
        void'(expQ.pop_front());
        clear_inputs();
      end
      ra[0] = 5'd4; ra[2] = 5'd4;
      drive_cycle();
      e = expQ.pop_front();
      checks++;
      if (rdPending[0] !== wantPend[step][0] || rdPending[2] !== wantPend[step][0] ||
          e.pend[0] !== wantPend[step][0]) begin
        errors++;
        $display("FAIL scoreboard_step%0d got %b want %b", step, rdPending[0],
                 wantPend[step][0]);
      end
      checks++;
      if (rdData[31:0] !== e.data[0]) begin
        errors++;
        $display("FAIL scoreboard_data%0d got %h want %h", step, rdData[31:0], e.data[0]);
      end
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    we = 4'hF; se = 4'hF;
    for (int i = 0; i < 4; i++) wd[i] = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      drive_cycle();
      void'(expQ.pop_front());
      checks++;
      if (rdData !== '0 || rdPending !== '0 || writeConflict !== 1'b0) begin
        errors++;
        $display("FAIL zero_reg%0d got data=%h pend=%b conf=%b want all zero",
                 k, rdData, rdPending, writeConflict);
      end
      clear_inputs();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 40; k++) begin
      we = 4'($urandom);
      se = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        wa[i] = 5'($urandom_range(0, 7));
        sa[i] = 5'($urandom_range(0, 7));
        ra[i] = (k % 5 == 0) ? 5'd3 : 5'($urandom_range(0, 7));
        wd[i] = $urandom;
      end
      drive_cycle();
      e = expQ.pop_front();
      checks++;
      if (rdData !== 128'(e.data) || rdPending !== e.pend || writeConflict !== e.conflict) begin
        errors++;
        $display("FAIL back_to_back%0d got %h/%b/%b want %h/%b/%b", k, rdData, rdPending,
                 writeConflict, e.data, e.pend, e.conflict);
      end
    end
    clear_inputs();
  endtask

  task automatic test_params();
    bWrEn = 2'b01;
    bWrAddr[5:0] = 6'd63;
    bWrData[63:0] = 64'h0123456789ABCDEF;
    @(posedge clk);
    #1;
    bWrEn = '0;
    for (int r = 0; r < 6; r++) bRdAddr[r*6 +: 6] = 6'd63;
    @(posedge clk);
    #1;
    for (int r = 0; r < 6; r++) begin
      checks++;
      if (bRdData[r*64 +: 64] !== 64'h0123456789ABCDEF || bRdPending[r] !== 1'b0) begin
        errors++;
        $display("FAIL params_read%0d got %h/%b want %h/0", r, bRdData[r*64 +: 64],
                 bRdPending[r], 64'h0123456789ABCDEF);
      end
    end
  endtask

  initial begin
    resetN = 1'b0;
    rdAddr = '0; wrEn = '0; wrAddr = '0; wrData = '0; rsvEn = '0; rsvAddr = '0;
    bRdAddr = '0; bWrEn = '0; bWrAddr = '0; bWrData = '0; bRsvEn = '0; bRsvAddr = '0;
    clear_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_zero_reg();
    test_back_to_back();
    test_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
